// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD result queue slice.
// The gcd_result_t cycles field exists only when GCD_CYCLES_EN is defined.
package gcd_pkg;

    localparam int unsigned GCD_DATA_W     = 32;
    localparam int unsigned GCD_CYCLES_W   = 32;
    localparam int unsigned GCD_S_BUSY_BIT = 3;

    localparam logic [8:0] GCD_ADDR_A1 = 9'h0F8;
    localparam logic [8:0] GCD_ADDR_A2 = 9'h0FC;
    localparam logic [8:0] GCD_ADDR_W  = 9'h100;
    localparam logic [8:0] GCD_ADDR_S  = 9'h104;

    typedef struct packed {
        logic [GCD_DATA_W-1:0]   a1;
        logic [GCD_DATA_W-1:0]   a2;
        logic [GCD_DATA_W-1:0]   w;
`ifdef GCD_CYCLES_EN
        logic [GCD_CYCLES_W-1:0] cycles;
`endif
    } gcd_result_t;

endpackage

// File: rtl/gcd_fifo_mem.sv
// First-word-fall-through storage for completed GCD results.
// Reads as all-zero while empty; a pop on a full queue frees room for a same-cycle push.
module gcd_fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/gcd_result_queue.sv
// Captures GCD core jobs from the busy bit and queues {A1, A2, W[, cycles]} for software.
// Define GCD_CYCLES_EN to add the per-job cycle counter and the rd_cycles port.
module gcd_result_queue
    import gcd_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_busy,
    input  logic [DATA_W-1:0]        core_a1,
    input  logic [DATA_W-1:0]        core_a2,
    input  logic [DATA_W-1:0]        core_w,
    input  logic                     pop,
    input  logic                     clr_ovf,
    output logic [DATA_W-1:0]        rd_a1,
    output logic [DATA_W-1:0]        rd_a2,
    output logic [DATA_W-1:0]        rd_w,
`ifdef GCD_CYCLES_EN
    output logic [31:0]              rd_cycles,
`endif
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

`ifdef GCD_CYCLES_EN
    localparam int unsigned ENTRY_W = 3*DATA_W + GCD_CYCLES_W;
`else
    localparam int unsigned ENTRY_W = 3*DATA_W;
`endif

    logic               busy_q;
    logic               armed;
    logic [DATA_W-1:0]  hold_a1;
    logic [DATA_W-1:0]  hold_a2;
    logic               start;
    logic               complete;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign start    = core_busy & ~busy_q;
    assign complete = busy_q & ~core_busy & armed;
    assign drop     = complete & full & ~pop;

    // busy_q resets high so a job already running when reset lifts is never armed
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b1;
            armed   <= 1'b0;
            hold_a1 <= '0;
            hold_a2 <= '0;
        end else begin
            busy_q <= core_busy;
            if (start) begin
                hold_a1 <= core_a1;
                hold_a2 <= core_a2;
                armed   <= 1'b1;
            end else if (complete) begin
                armed   <= 1'b0;
            end
        end
    end

`ifdef GCD_CYCLES_EN
    logic [GCD_CYCLES_W-1:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (start) begin
            cycle_cnt <= GCD_CYCLES_W'(1);
        end else if (core_busy && armed && cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + GCD_CYCLES_W'(1);
        end
    end

    assign wr_entry = {hold_a1, hold_a2, core_w, cycle_cnt};
    assign {rd_a1, rd_a2, rd_w, rd_cycles} = rd_entry;
`else
    assign wr_entry = {hold_a1, hold_a2, core_w};
    assign {rd_a1, rd_a2, rd_w} = rd_entry;
`endif

    // Drop-set has priority over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    gcd_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (complete),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

endmodule

// File: tb/tb_gcd_result_queue.sv
// Scoreboard bench for gcd_result_queue: job-level reference queue versus DUT outputs.
// Checks the cycles field only when GCD_CYCLES_EN is defined.
module tb_gcd_result_queue;
    import gcd_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              core_busy;
    logic [DATA_W-1:0] core_a1;
    logic [DATA_W-1:0] core_a2;
    logic [DATA_W-1:0] core_w;
    logic              pop;
    logic              clr_ovf;
    logic [DATA_W-1:0] rd_a1;
    logic [DATA_W-1:0] rd_a2;
    logic [DATA_W-1:0] rd_w;
`ifdef GCD_CYCLES_EN
    logic [31:0]       rd_cycles;
`endif
    logic              empty;
    logic              full;
    logic [3:0]        level;
    logic              overflow;

    gcd_result_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core_busy (core_busy),
        .core_a1   (core_a1),
        .core_a2   (core_a2),
        .core_w    (core_w),
        .pop       (pop),
        .clr_ovf   (clr_ovf),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .rd_w      (rd_w),
`ifdef GCD_CYCLES_EN
        .rd_cycles (rd_cycles),
`endif
        .empty     (empty),
        .full      (full),
        .level     (level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          clr_pct  = 0;
    bit          mon_en   = 0;
    bit          m_ovf    = 0;
    gcd_result_t mq[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT head/status against the reference queue between edges
    initial begin : monitor
        gcd_result_t h;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                h = '0;
                if (mq.size() > 0) h = mq[0];
                check32("level",    32'(level),    32'(mq.size()));
                check32("empty",    32'(empty),    32'(mq.size() == 0));
                check32("full",     32'(full),     32'(mq.size() == DEPTH));
                check32("overflow", 32'(overflow), 32'(m_ovf));
                check32("rd_a1",    rd_a1,         h.a1);
                check32("rd_a2",    rd_a2,         h.a2);
                check32("rd_w",     rd_w,          h.w);
`ifdef GCD_CYCLES_EN
                check32("rd_cycles", rd_cycles,    h.cycles);
`endif
            end
        end
    end

    // Reference: one clock of queue behaviour given this cycle's pop/completion/clear
    task automatic model_step(input bit p, input bit push_en, input gcd_result_t e, input bit c);
        bit dropped;
        dropped = 0;
        if (p && mq.size() > 0) void'(mq.pop_front());
        if (push_en) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (c) m_ovf = 0;
    endtask

    task automatic tick(input logic b, input logic p, input logic c);
        core_busy = b;
        pop       = p;
        clr_ovf   = c;
        @(posedge clk);
        #1;
    endtask

    function automatic bit roll(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic idle(input int n, input int pop_pct, input bit force_pop, input bit force_clr);
        gcd_result_t z;
        bit p, c;
        z = '0;
        for (int i = 0; i < n; i++) begin
            p = force_pop | roll(pop_pct);
            c = force_clr | roll(clr_pct);
            tick(1'b0, p, c);
            model_step(p, 1'b0, z, c);
        end
    endtask

    // One job: n cycles with busy high, then one completion cycle with busy low
    task automatic run_job(input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] w,
                           input int n, input int pop_pct, input bit pop_end, input bit chg);
        gcd_result_t e, z;
        bit p, c;
        z = '0;
        core_a1 = a1;
        core_a2 = a2;
        core_w  = $urandom;
        for (int i = 0; i < n; i++) begin
            p = roll(pop_pct);
            c = roll(clr_pct);
            tick(1'b1, p, c);
            model_step(p, 1'b0, z, c);
            if (chg) begin
                core_a1 = (i == 0) ? 32'd99 : $urandom;
                core_a2 = $urandom;
            end
        end
        e    = '0;
        e.a1 = a1;
        e.a2 = a2;
        e.w  = w;
`ifdef GCD_CYCLES_EN
        e.cycles = 32'(n);
`endif
        core_w = w;
        p = pop_end | roll(pop_pct);
        c = roll(clr_pct);
        tick(1'b0, p, c);
        model_step(p, 1'b1, e, c);
    endtask

    initial begin : driver
        reset     = 1'b1;
        core_busy = 1'b0;
        core_a1   = '0;
        core_a2   = '0;
        core_w    = '0;
        pop       = 1'b0;
        clr_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        m_ovf  = 0;
        mon_en = 1;
        tick(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        idle(1, 0, 0, 0);

        // Single job with operand change mid-job, then pop back to empty
        run_job(32'd48, 32'd18, 32'd6, 5, 0, 0, 1);
        idle(2, 0, 0, 0);
        idle(1, 0, 1, 0);

        // Nine jobs, no pops: ninth is dropped, then overflow cleared
        for (int k = 1; k <= 9; k++)
            run_job($urandom, $urandom, 32'(k), $urandom_range(4, 1), 0, 0, 0);
        idle(1, 0, 0, 1);

        // Full queue: completion and pop on the same edge, then drain
        run_job($urandom, $urandom, 32'd77, 3, 0, 1, 0);
        idle(8, 0, 1, 0);

        // Pops on empty, then a push must read back correctly
        idle(3, 0, 1, 0);
        run_job(32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0011, 2, 0, 0, 0);
        idle(1, 0, 1, 0);

        // Randomized jobs, back-to-back when gap is zero
        clr_pct = 12;
        for (int j = 0; j < 60; j++) begin
            run_job($urandom, $urandom, $urandom, $urandom_range(6, 1),
                    30, 0, bit'($urandom_range(1)));
            idle($urandom_range(2), 50, 0, 0);
        end
        clr_pct = 0;

        // Reset mid-job: in-flight job and queue contents are discarded
        run_job(32'd5, 32'd7, 32'd1, 2, 0, 0, 0);
        core_a1 = 32'd100;
        core_a2 = 32'd200;
        tick(1'b1, 1'b0, 1'b0);
        model_step(1'b0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            mq.delete();
            m_ovf = 0;
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            model_step(1'b0, 1'b0, '0, 1'b0);
        end
        idle(3, 0, 0, 0);

        // Fresh job after the reset sequence is captured normally
        run_job(32'd21, 32'd14, 32'd7, 3, 0, 0, 0);
        idle(2, 0, 0, 0);

        @(negedge clk);
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
